// File: rtl/sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver
//
// Time-multiplexes a 16-bit counter value onto a 4-digit common-anode
// 7-segment display as hexadecimal, one digit per scan slot of DIV cycles.
// The value (plus the up/down terminal-count flags) is captured into a
// shadow register once per frame, so a frame never mixes two counts.
// The first GUARD cycles of every slot keep all anodes off to suppress
// ghosting while the segment pattern changes.
//
// Parameters:
//   DIV    clock cycles per digit slot (DIV >= 2, DIV >= GUARD+1)
//   GUARD  dark cycles at the start of each slot (0 <= GUARD < DIV)
//
// Ports:
//   clk_i       in   1   system clock, rising edge
//   rst_ni      in   1   asynchronous active-low reset
//   val_i       in  16   counter value to display
//   utc_i       in   1   up terminal count (value == 0xFFFF)
//   dtc_i       in   1   down terminal count (value == 0x0000)
//   blank_lz_i  in   1   1 = blank leading zero digits (sampled live)
//   an_o        out  4   anode enables, active-low, bit k = digit k
//   seg_o       out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp_o        out  1   decimal point, active-low
//   frame_o     out  1   one-cycle pulse when a new snapshot is taken
// ---------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int DIV   = 1000,
  parameter int GUARD = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] val_i,
  input  logic        utc_i,
  input  logic        dtc_i,
  input  logic        blank_lz_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  // Hex digit to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // True when nibbles k..3 of v are all zero (digit k is a leading zero).
  function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] k);
    logic z;
    case (k)
      2'd0:    z = (v == 16'h0000);
      2'd1:    z = (v[15:4] == 12'h000);
      2'd2:    z = (v[15:8] == 8'h00);
      2'd3:    z = (v[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  logic [CW-1:0] cnt_r;
  logic [1:0]    d_r;
  logic [15:0]   shadow_r;
  logic          sh_utc_r;
  logic          sh_dtc_r;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;
  logic          frame_r;

  logic          tick_s;
  logic          guard_s;
  logic          blanked_s;
  logic [3:0]    nib_s;
  logic [3:0]    an_next_s;
  logic [6:0]    seg_next_s;
  logic          dp_next_s;

  assign tick_s = (cnt_r == CNT_MAX);

  // With GUARD == 0 there is no dark interval; avoid a constant compare.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_s = 1'b0;
    end else begin : g_guard
      assign guard_s = (cnt_r < CW'(GUARD));
    end
  endgenerate

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    nib_s = 4'h0;
    case (d_r)
      2'd0:    nib_s = shadow_r[3:0];
      2'd1:    nib_s = shadow_r[7:4];
      2'd2:    nib_s = shadow_r[11:8];
      2'd3:    nib_s = shadow_r[15:12];
      default: nib_s = 4'h0;
    endcase
  end

  // Digit 0 always shows, even for a value of zero.
  assign blanked_s = blank_lz_i && (d_r != 2'd0) && upper_zero(shadow_r, d_r);

  // Next display drive for the current (cnt, d, shadow).
  always_comb begin
    an_next_s  = 4'hF;
    seg_next_s = 7'h7F;
    dp_next_s  = 1'b1;
    if (guard_s || blanked_s) begin
      an_next_s  = 4'hF;
      seg_next_s = 7'h7F;
      dp_next_s  = 1'b1;
    end else begin
      an_next_s  = ~(4'b0001 << d_r);
      seg_next_s = hex_to_seg(nib_s);
      // utc and dtc may both be set; each point follows its own flag.
      if (((d_r == 2'd0) && sh_dtc_r) || ((d_r == 2'd3) && sh_utc_r)) begin
        dp_next_s = 1'b0;
      end else begin
        dp_next_s = 1'b1;
      end
    end
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
      d_r   <= 2'd0;
    end else if (tick_s) begin
      cnt_r <= '0;
      d_r   <= d_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
      d_r   <= d_r;
    end
  end

  // Frame snapshot of value and terminal-count flags, with frame pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_r <= 16'h0000;
      sh_utc_r <= 1'b0;
      sh_dtc_r <= 1'b0;
      frame_r  <= 1'b0;
    end else if (tick_s && (d_r == 2'd3)) begin
      shadow_r <= val_i;
      sh_utc_r <= utc_i;
      sh_dtc_r <= dtc_i;
      frame_r  <= 1'b1;
    end else begin
      frame_r  <= 1'b0;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_r  <= 4'hF;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
    end
  end

  assign an_o    = an_r;
  assign seg_o   = seg_r;
  assign dp_o    = dp_r;
  assign frame_o = frame_r;

endmodule
